// File: rtl/orient_hist.sv
// Keypoint orientation-histogram accumulator: bins (magnitude, angle) samples per window,
// then scans the bins and reports the dominant orientation and its weight.
module orient_hist #(
  parameter int DW    = 16,
  parameter int NORM  = 20,
  parameter int ACC_W = 24,
  parameter int NBINS = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_mag,
  input  logic [NORM-1:0]  in_ang,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [5:0]       out_bin,
  output logic [ACC_W-1:0] out_peak,
  output logic             out_valid,
  output logic             err_drop
);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [NORM+5:0] NBINS_K  = (NORM+6)'(NBINS);
  localparam logic [5:0]      LAST_BIN = 6'(NBINS-1);
  localparam logic [5:0]      FLUSH_END = 6'd1;

  // Saturating accumulate; the extra carry bit detects overflow.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [DW-1:0]    mag);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W+1-DW){1'b0}}, mag};
    if (sum[ACC_W]) begin
      sat_add = {ACC_W{1'b1}};
    end else begin
      sat_add = sum[ACC_W-1:0];
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_drop_q;
  logic [5:0]       out_bin_q, out_bin_d;
  logic [ACC_W-1:0] out_peak_q, out_peak_d;
  logic [5:0]       max_bin_q, max_bin_d;
  logic [ACC_W-1:0] max_val_q, max_val_d;

  logic             s1_valid_q;
  logic [5:0]       s1_bin_q;
  logic [DW-1:0]    s1_mag_q;

  logic [ACC_W-1:0] hist_q [NBINS];

  logic             accept_s;
  logic [NORM+5:0]  prod_s;
  logic [5:0]       bin_s;
  logic [ACC_W-1:0] scan_val_s;
  logic             scan_gt_s;

  assign accept_s   = in_valid & in_ready_q;
  assign prod_s     = {6'd0, in_ang} * NBINS_K;
  assign bin_s      = prod_s[NORM+5:NORM];
  assign scan_val_s = hist_q[cnt_q];
  assign scan_gt_s  = scan_val_s > max_val_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_peak  = out_peak_q;
  assign err_drop  = err_drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_ACCUM: begin
        if (accept_s && in_last) begin
          state_d = S_FLUSH;
          cnt_d   = 6'd0;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_END) begin
          state_d = S_SCAN;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_SCAN: begin
        if (cnt_q == LAST_BIN) begin
          state_d = S_DONE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_ACCUM;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = S_ACCUM;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Running maximum; strictly-greater keeps the lowest index on ties.
  always_comb begin
    max_val_d  = max_val_q;
    max_bin_d  = max_bin_q;
    out_bin_d  = out_bin_q;
    out_peak_d = out_peak_q;
    if (state_q == S_FLUSH) begin
      max_val_d = {ACC_W{1'b0}};
      max_bin_d = 6'd0;
    end else if (state_q == S_SCAN) begin
      if (scan_gt_s) begin
        max_val_d = scan_val_s;
        max_bin_d = cnt_q;
      end else begin
        max_val_d = max_val_q;
        max_bin_d = max_bin_q;
      end
      if (cnt_q == LAST_BIN) begin
        out_bin_d  = max_bin_d;
        out_peak_d = max_val_d;
      end else begin
        out_bin_d  = out_bin_q;
        out_peak_d = out_peak_q;
      end
    end else begin
      max_val_d = max_val_q;
      max_bin_d = max_bin_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      cnt_q       <= 6'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_drop_q  <= 1'b0;
      out_bin_q   <= 6'd0;
      out_peak_q  <= {ACC_W{1'b0}};
      max_bin_q   <= 6'd0;
      max_val_q   <= {ACC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_ACCUM);
      out_valid_q <= (state_d == S_DONE);
      err_drop_q  <= err_drop_q | (in_valid & ~in_ready_q);
      out_bin_q   <= out_bin_d;
      out_peak_q  <= out_peak_d;
      max_bin_q   <= max_bin_d;
      max_val_q   <= max_val_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= 6'd0;
      s1_mag_q   <= {DW{1'b0}};
    end else begin
      s1_valid_q <= accept_s;
      s1_bin_q   <= bin_s;
      s1_mag_q   <= in_mag;
    end
  end

  // One read-modify-write per cycle, so back-to-back hits on a bin see the prior update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBINS; i++) begin
        hist_q[i] <= {ACC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        if (state_q == S_DONE) begin
          hist_q[i] <= {ACC_W{1'b0}};
        end else if (s1_valid_q && (s1_bin_q == 6'(i))) begin
          hist_q[i] <= sat_add(hist_q[i], s1_mag_q);
        end else begin
          hist_q[i] <= hist_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_orient_hist.sv
// Directed bench for orient_hist: a window-level model checked every cycle, plus literal pins.
module tb_orient_hist;
  localparam int NBINS = 36;
  localparam int SAT   = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_mag = 16'd0;
  logic [19:0] in_ang = 20'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [5:0]  out_bin;
  logic [23:0] out_peak;
  logic        out_valid;
  logic        err_drop;

  orient_hist dut (
    .clk(clk), .rst(rst), .in_mag(in_mag), .in_ang(in_ang),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_bin(out_bin), .out_peak(out_peak), .out_valid(out_valid),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rst_last_edge = 1'b1;

  // Window-level model state
  int m_hist [NBINS];
  int last_cyc = -1000;
  bit m_err = 1'b0;
  int exp_bin = 0, exp_peak = 0, pend_bin = 0, pend_peak = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_last_edge = rst;
  end

  // Compare process: the model reasons in whole windows and cycle offsets from the last beat.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < NBINS; i++) m_hist[i] = 0;
      last_cyc = -1000; m_err = 1'b0; exp_bin = 0; exp_peak = 0;
      chk("m_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("m_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("m_rst_bin", {26'd0, out_bin}, 32'd0);
      chk("m_rst_peak", {8'd0, out_peak}, 32'd0);
      chk("m_rst_err", {31'd0, err_drop}, 32'd0);
    end else begin
      automatic bit ready_e = !rst_last_edge &&
                              !(last_cyc >= 0 && cyc > last_cyc && cyc <= last_cyc + 39);
      automatic bit valid_e = (last_cyc >= 0 && cyc == last_cyc + 39);
      if (valid_e) begin
        exp_bin = pend_bin; exp_peak = pend_peak;
      end
      chk("m_ready", {31'd0, in_ready}, {31'd0, ready_e});
      chk("m_valid", {31'd0, out_valid}, {31'd0, valid_e});
      chk("m_err", {31'd0, err_drop}, {31'd0, m_err});
      chk("m_bin", {26'd0, out_bin}, exp_bin);
      chk("m_peak", {8'd0, out_peak}, exp_peak);
      if (in_valid && ready_e) begin
        automatic int b = int'((longint'(in_ang) * NBINS) / 64'd1048576);
        m_hist[b] = m_hist[b] + int'(in_mag);
        if (m_hist[b] > SAT) m_hist[b] = SAT;
        if (in_last) begin
          pend_bin = 0; pend_peak = m_hist[0];
          for (int i = 1; i < NBINS; i++)
            if (m_hist[i] > pend_peak) begin pend_bin = i; pend_peak = m_hist[i]; end
          for (int i = 0; i < NBINS; i++) m_hist[i] = 0;
          last_cyc = cyc;
        end
      end else if (in_valid) begin
        m_err = 1'b1;
      end
    end
  end

  task automatic send(input logic [15:0] mag, input logic [19:0] ang, input logic last);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mag = mag; in_ang = ang; in_last = last;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string name, input int eb, input int ep);
    bit seen = 1'b0;
    idle();
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: out_valid not seen, expected within 80 cycles", name);
    end else begin
      chk({name, "_bin"}, {26'd0, out_bin}, eb);
      chk({name, "_peak"}, {8'd0, out_peak}, ep);
      chk({name, "_busy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
      chk({name, "_strobe_off"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single beat
    send(16'd100, 20'h80000, 1'b1);
    wait_result("single", 18, 100);

    // Bin edges
    send(16'd5, 20'd29127, 1'b1);  wait_result("edge0", 0, 5);
    send(16'd5, 20'd29128, 1'b1);  wait_result("edge1", 1, 5);
    send(16'd5, 20'hFFFFF, 1'b1);  wait_result("edge35", 35, 5);

    // Back-to-back same bin, then saturation
    for (int i = 0; i < 10; i++) send(16'hFFFF, 20'h40000, i == 9);
    wait_result("b2b", 9, 655350);
    for (int i = 0; i < 300; i++) send(16'hFFFF, 20'h40000, i == 299);
    wait_result("sat", 9, SAT);

    // Tie between bins 3 and 20, then a cleared-bins check
    send(16'd200, 20'd582543, 1'b0);
    send(16'd250, 20'd87382, 1'b0);
    send(16'd300, 20'd582543, 1'b0);
    send(16'd250, 20'd87382, 1'b1);
    wait_result("tie", 3, 500);
    send(16'd1, 20'd203890, 1'b1);
    wait_result("cleared", 7, 1);

    // Backpressure: in_valid held through the busy cycles 1..39
    send(16'd9, 20'd58255, 1'b1);
    for (int k = 1; k <= 39; k++) send(16'd1000, 20'd0, 1'b0);
    idle();
    @(negedge clk);
    chk("bp_err", {31'd0, err_drop}, 32'd1);
    chk("bp_bin", {26'd0, out_bin}, 32'd2);
    chk("bp_peak", {8'd0, out_peak}, 32'd9);
    chk("bp_ready", {31'd0, in_ready}, 32'd1);
    send(16'd3, 20'd0, 1'b1);
    wait_result("bp_next", 0, 3);

    // Async reset in the middle of the scan
    send(16'd50, 20'd0, 1'b0);
    send(16'd50, 20'd0, 1'b1);
    idle();
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_bin", {26'd0, out_bin}, 32'd0);
    chk("arst_peak", {8'd0, out_peak}, 32'd0);
    chk("arst_err", {31'd0, err_drop}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(16'd7, 20'd0, 1'b1);
    wait_result("post_rst", 0, 7);

    repeat (3) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
